ps2_host_cmd_ctrl: RTL
======================

// Module: ps2_host_cmd_ctrl
// PURPOSE
//  Avalon-MM slave that sends host-to-device commands to the PS/2 keyboard (e.g. 0xED set-LEDs, 0xFF reset).
//  Sequence per command: inhibit the line, request-to-send, shift out the frame, check the line ACK, then wait
//  for the device reply (0xFA ack / 0xFE resend) on the receive path.
//  It shares the PS/2 pins with the scancode receiver and gates the receiver (rx_enable) while it owns the bus.
// PARAMETERS
//  CLK_HZ          50_000_000  csi_clk frequency
//  INHIBIT_CYC     5000        cycles kc is held low before RTS (100 us @ 50 MHz)
//  TIMEOUT_CYC     750_000     max cycles per command, from leaving IDLE (15 ms)
//  MAX_RETRY       3           resends honoured before RESEND_ERR
// PORTS
//  csi_clk           in   1  system clock
//  csi_reset_n       in   1  asynchronous, active-low reset
//  avs_s1_address    in   2  0=CMD/RESP 1=STATUS 2=CTRL
//  avs_s1_read       in   1  read strobe; readdata registered, 1-cycle latency
//  avs_s1_write      in   1  write strobe
//  avs_s1_writedata  in   8  write data
//  avs_s1_readdata   out  8  read data
//  ins_irq0_irq      out  1  level irq = irq_en & (done|err)
//  coe_kc_in         in   1  PS/2 clock pin, raw
//  coe_kd_in         in   1  PS/2 data pin, raw
//  coe_kc_oe         out  1  1 = pull kc low (open drain)
//  coe_kd_oe         out  1  1 = pull kd low (open drain)
//  rx_valid          in   1  1-cycle pulse, byte from scancode receiver
//  rx_data           in   8  received byte
//  rx_enable         out  1  0 while a frame is being transmitted
// BEHAVIOUR
//  Reset: all outputs 0 except rx_enable=1. State=IDLE, STATUS=0, CTRL=0, RESP=0, retry count=0.
//   Async reset mid-frame releases both pins immediately.
//  Pin sync: kc/kd through 2-FF synchronisers. kc_fall = sync_kc(n-1)=1 & sync_kc(n)=0.
//  Register map:
//   CMD (wr)    latches byte and starts a command (IDLE -> INHIBIT) only when not busy.
//               A write while busy is dropped and sets STATUS.ovr.
//   RESP (rd)   last byte received in WAIT_RESP.
//   STATUS      [0]busy [1]done [2]ack_err [3]timeout [4]resend_err [5]ovr.
//               Writing 1 clears bits [1..5]. A set event in the same cycle wins over the clear.
//   CTRL        [0]irq_en.
//  FSM:
//   IDLE        kc_oe=kd_oe=0, rx_enable=1.
//   INHIBIT     kc_oe=1, rx_enable=0, for INHIBIT_CYC cycles -> RTS.
//   RTS         kd_oe=1, kc_oe=0 -> SEND.
//   SEND        bit index 0..9 = data[0..7], odd parity, stop(1).
//               On each kc_fall, advance to the next bit; kd_oe = ~bit.
//               The stop bit releases kd. After the kc_fall ending the stop bit -> LACK.
//   LACK        on next kc_fall sample kd: 0 -> WAIT_RESP (rx_enable=1); 1 -> set ack_err -> IDLE.
//   WAIT_RESP   on rx_valid latch RESP.
//                0xFA  -> set done -> IDLE.
//                0xFE  -> if retry<MAX_RETRY then retry++, resend same byte via INHIBIT; else set resend_err -> IDLE.
//                other -> stored, keep waiting.
//  Timeout: counter runs in every non-IDLE state and resets only on leaving IDLE (not on retry).
//   Reaching TIMEOUT_CYC forces IDLE, releases pins and sets timeout.
//  busy = (state != IDLE). Retry count clears on CMD accept.
//  rx_valid outside WAIT_RESP is ignored by this block.
//  readdata updates on the read cycle only; no read side effects.
// STRUCTURE
//  Shared package ps2_pkg: state enum, register addresses, STATUS bit indices, PS2_ACK=8'hFA, PS2_RESEND=8'hFE.
//  Sub-module ps2_tx_shifter: takes byte+start+kc_fall; produces kd_oe, bit_done, and parity.
//   Parity = ~^data.
//  Top holds the FSM, timers, registers and pin synchronisers.
// TESTING
//  1. Write CMD=0xED. Device model clocks the frame and ACKs, replies 0xFA.
//     -> kd bits 1,0,1,1,0,1,1,1, parity 1; STATUS=0x02; RESP=0xFA; irq=1 if irq_en.
//  2. Device replies 0xFE twice, then 0xFA.
//     -> frame sent 3 times with identical bits; STATUS=0x02.
//  3. Device always replies 0xFE.
//     -> 4 frames (1 + MAX_RETRY); STATUS=0x10; pins released.
//  4. Device never clocks after RTS.
//     -> at TIMEOUT_CYC STATUS=0x08, kc_oe=kd_oe=0, rx_enable=1.
//  5. Second CMD write during SEND -> ignored, STATUS.ovr=1.
//     Write 0x3E to STATUS -> bits cleared, busy unaffected.
//  6. Assert csi_reset_n=0 mid-SEND (bit 4).
//     -> kc_oe=kd_oe=0 asynchronously; after release state IDLE, STATUS=0x00.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host command controller:
// FSM states, register addresses, STATUS bit positions and device reply codes.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_RTS,
    ST_SEND,
    ST_LACK,
    ST_WAIT_RESP
  } ps2_state_e;

  localparam logic [1:0] ADDR_CMD    = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;

  localparam int STB_BUSY       = 0;
  localparam int STB_DONE       = 1;
  localparam int STB_ACK_ERR    = 2;
  localparam int STB_TIMEOUT    = 3;
  localparam int STB_RESEND_ERR = 4;
  localparam int STB_OVR        = 5;

  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_RESEND = 8'hFE;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_host_cmd_ctrl_if.sv
// Avalon-MM slave bus of the PS/2 command controller (2-bit word address, 8-bit data,
// readdata registered with one cycle of latency).
interface ps2_host_cmd_ctrl_if;
  logic [1:0] avs_s1_address;
  logic       avs_s1_read;
  logic       avs_s1_write;
  logic [7:0] avs_s1_writedata;
  logic [7:0] avs_s1_readdata;

  modport master (output avs_s1_address, avs_s1_read, avs_s1_write, avs_s1_writedata,
                  input  avs_s1_readdata);
  modport slave  (input  avs_s1_address, avs_s1_read, avs_s1_write, avs_s1_writedata,
                  output avs_s1_readdata);
endinterface

// File: rtl/ps2_tx_shifter.sv
// Serialises one host-to-device frame (data LSB first, odd parity, stop) on PS/2 clock falls.
// kd_oe starts asserted (start bit) on start_i; bit_done_o pulses on the fall that ends the stop bit.
module ps2_tx_shifter
  import ps2_pkg::*;
(
  input  logic       csi_clk,
  input  logic       csi_reset_n,
  input  logic       start_i,
  input  logic [7:0] data_i,
  input  logic       kc_fall_i,
  output logic       kd_oe_o,
  output logic       bit_done_o
);

  logic [9:0] frame_q;
  logic [3:0] idx_q;
  logic       active_q;
  logic       kd_oe_q;

  always_ff @(posedge csi_clk or negedge csi_reset_n) begin
    if (!csi_reset_n) begin
      frame_q  <= '0;
      idx_q    <= '0;
      active_q <= 1'b0;
      kd_oe_q  <= 1'b0;
    end else if (start_i) begin
      frame_q  <= {1'b1, odd_parity(data_i), data_i};
      idx_q    <= '0;
      active_q <= 1'b1;
      kd_oe_q  <= 1'b1;
    end else if (active_q && kc_fall_i) begin
      // idx 10 means the stop bit is on the wire and this fall ends it
      if (idx_q == 4'd10) begin
        active_q <= 1'b0;
      end else begin
        kd_oe_q <= ~frame_q[idx_q];
        idx_q   <= idx_q + 4'd1;
      end
    end
  end

  assign kd_oe_o    = kd_oe_q;
  assign bit_done_o = active_q & kc_fall_i & ~start_i & (idx_q == 4'd10);

endmodule

// File: rtl/ps2_host_cmd_ctrl.sv
// PS/2 host-to-device command engine behind an Avalon-MM slave: inhibit, RTS, shift out, line ACK,
// then wait for the 0xFA/0xFE reply. Owns the open-drain kc/kd pins and gates the shared receiver.
module ps2_host_cmd_ctrl
  import ps2_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int INHIBIT_CYC = CLK_HZ / 10_000,
  parameter int TIMEOUT_CYC = CLK_HZ / 1_000 * 15,
  parameter int MAX_RETRY   = 3
) (
  input  logic               csi_clk,
  input  logic               csi_reset_n,
  ps2_host_cmd_ctrl_if.slave avs,
  output logic               ins_irq0_irq,
  input  logic               coe_kc_in,
  input  logic               coe_kd_in,
  output logic               coe_kc_oe,
  output logic               coe_kd_oe,
  input  logic               rx_valid,
  input  logic [7:0]         rx_data,
  output logic               rx_enable
);

  localparam int INH_W = $clog2(INHIBIT_CYC + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam int RTY_W = $clog2(MAX_RETRY + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYC - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

  ps2_state_e               state_q, state_d;
  logic [INH_W-1:0]         inh_q;
  logic [TMO_W-1:0]         tmo_q;
  logic [RTY_W-1:0]         retry_q;
  logic [7:0]               cmd_q, resp_q, rdata_q, rd_mux;
  logic [STB_OVR:STB_DONE]  sticky_q, sticky_d;
  logic                     irq_en_q;
  logic [2:0]               kc_sync_q;
  logic [1:0]               kd_sync_q;

  logic kc_fall, kd_s, busy, cmd_wr, cmd_accept, st_wr, ctrl_wr;
  logic shift_start, shift_kd_oe, shift_done;
  logic set_done, set_ack_err, set_timeout, set_resend_err, retry_inc, resp_ld;

  // Pins idle high, so synchronisers reset to 1 to avoid a phantom fall out of reset
  always_ff @(posedge csi_clk or negedge csi_reset_n) begin
    if (!csi_reset_n) begin
      kc_sync_q <= 3'b111;
      kd_sync_q <= 2'b11;
    end else begin
      kc_sync_q <= {kc_sync_q[1:0], coe_kc_in};
      kd_sync_q <= {kd_sync_q[0], coe_kd_in};
    end
  end

  assign kc_fall    = kc_sync_q[2] & ~kc_sync_q[1];
  assign kd_s       = kd_sync_q[1];
  assign busy       = (state_q != ST_IDLE);
  assign cmd_wr     = avs.avs_s1_write && (avs.avs_s1_address == ADDR_CMD);
  assign st_wr      = avs.avs_s1_write && (avs.avs_s1_address == ADDR_STATUS);
  assign ctrl_wr    = avs.avs_s1_write && (avs.avs_s1_address == ADDR_CTRL);
  assign cmd_accept = cmd_wr && !busy;

  ps2_tx_shifter u_shifter (
    .csi_clk     (csi_clk),
    .csi_reset_n (csi_reset_n),
    .start_i     (shift_start),
    .data_i      (cmd_q),
    .kc_fall_i   (kc_fall),
    .kd_oe_o     (shift_kd_oe),
    .bit_done_o  (shift_done)
  );

  always_ff @(posedge csi_clk or negedge csi_reset_n) begin
    if (!csi_reset_n) state_q <= ST_IDLE;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    coe_kc_oe      = 1'b0;
    coe_kd_oe      = 1'b0;
    rx_enable      = 1'b1;
    shift_start    = 1'b0;
    set_done       = 1'b0;
    set_ack_err    = 1'b0;
    set_timeout    = 1'b0;
    set_resend_err = 1'b0;
    retry_inc      = 1'b0;
    resp_ld        = 1'b0;
    case (state_q)
      ST_IDLE: if (cmd_accept) state_d = ST_INHIBIT;
      ST_INHIBIT: begin
        coe_kc_oe = 1'b1;
        rx_enable = 1'b0;
        if (inh_q == INH_LAST) state_d = ST_RTS;
      end
      ST_RTS: begin
        coe_kd_oe   = 1'b1;
        rx_enable   = 1'b0;
        shift_start = 1'b1;
        state_d     = ST_SEND;
      end
      ST_SEND: begin
        coe_kd_oe = shift_kd_oe;
        rx_enable = 1'b0;
        if (shift_done) state_d = ST_LACK;
      end
      ST_LACK: begin
        rx_enable = 1'b0;
        if (kc_fall) begin
          if (!kd_s) begin
            state_d = ST_WAIT_RESP;
          end else begin
            set_ack_err = 1'b1;
            state_d     = ST_IDLE;
          end
        end
      end
      ST_WAIT_RESP: begin
        if (rx_valid) begin
          resp_ld = 1'b1;
          if (rx_data == PS2_ACK) begin
            set_done = 1'b1;
            state_d  = ST_IDLE;
          end else if (rx_data == PS2_RESEND) begin
            if (retry_q < RTY_MAX) begin
              retry_inc = 1'b1;
              state_d   = ST_INHIBIT;
            end else begin
              set_resend_err = 1'b1;
              state_d        = ST_IDLE;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Command budget is global across retries; expiry overrides any other outcome
    if (busy && (tmo_q == TMO_LAST)) begin
      state_d        = ST_IDLE;
      set_timeout    = 1'b1;
      set_done       = 1'b0;
      set_ack_err    = 1'b0;
      set_resend_err = 1'b0;
      retry_inc      = 1'b0;
      shift_start    = 1'b0;
    end
  end

  // A write of 1 clears a sticky bit, but a same-cycle set event wins
  always_comb begin
    sticky_d = sticky_q;
    if (st_wr) sticky_d = sticky_q & ~avs.avs_s1_writedata[STB_OVR:STB_DONE];
    sticky_d[STB_DONE]       = sticky_d[STB_DONE] | set_done;
    sticky_d[STB_ACK_ERR]    = sticky_d[STB_ACK_ERR] | set_ack_err;
    sticky_d[STB_TIMEOUT]    = sticky_d[STB_TIMEOUT] | set_timeout;
    sticky_d[STB_RESEND_ERR] = sticky_d[STB_RESEND_ERR] | set_resend_err;
    sticky_d[STB_OVR]        = sticky_d[STB_OVR] | (cmd_wr & busy);
  end

  always_comb begin
    rd_mux = '0;
    case (avs.avs_s1_address)
      ADDR_CMD:    rd_mux = resp_q;
      ADDR_STATUS: begin
        rd_mux[STB_BUSY]         = busy;
        rd_mux[STB_OVR:STB_DONE] = sticky_q;
      end
      ADDR_CTRL:   rd_mux[0] = irq_en_q;
      default:     rd_mux = '0;
    endcase
  end

  always_ff @(posedge csi_clk or negedge csi_reset_n) begin
    if (!csi_reset_n) begin
      inh_q    <= '0;
      tmo_q    <= '0;
      retry_q  <= '0;
      cmd_q    <= '0;
      resp_q   <= '0;
      sticky_q <= '0;
      irq_en_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      inh_q    <= (state_q == ST_INHIBIT) ? inh_q + 1'b1 : '0;
      tmo_q    <= busy ? tmo_q + 1'b1 : '0;
      sticky_q <= sticky_d;
      if (cmd_accept) begin
        cmd_q   <= avs.avs_s1_writedata;
        retry_q <= '0;
      end else if (retry_inc) begin
        retry_q <= retry_q + 1'b1;
      end
      if (resp_ld)           resp_q   <= rx_data;
      if (ctrl_wr)           irq_en_q <= avs.avs_s1_writedata[0];
      if (avs.avs_s1_read)   rdata_q  <= rd_mux;
    end
  end

  assign avs.avs_s1_readdata = rdata_q;
  assign ins_irq0_irq = irq_en_q & (sticky_q[STB_DONE] | sticky_q[STB_ACK_ERR] |
                                    sticky_q[STB_TIMEOUT] | sticky_q[STB_RESEND_ERR]);

endmodule
